// File: rtl/windowed_regfile.sv
// rtl/windowed_regfile.sv - windowed SPARC V8 integer register file with CWP management
//
// Purpose:
//   Holds the 7 usable globals plus NWINDOWS overlapping windows of 16 words
//   (outs+locals). The ins of window w alias the outs of window w+1. It also
//   tracks the current window pointer across SAVE/RESTORE and flags window
//   overflow/underflow.
//
// Configuration macro:
//   WINDOW_TRAP_EN - when defined, wim blocks SAVE/RESTORE into invalid
//                    windows and raises wof_trap/wuf_trap; when undefined,
//                    wim is ignored and both trap outputs stay 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   rs1, rs2  in   architectural read addresses (5b)
//   rd        in   architectural write address (5b)
//   wr_data   in   write data (32b)
//   wr_en     in   write strobe
//   save      in   SAVE request (CWP - 1)
//   restore   in   RESTORE request (CWP + 1)
//   wim       in   window invalid mask (NWINDOWS bits)
//   rd1_data  out  registered read data, port 1
//   rd2_data  out  registered read data, port 2
//   cwp       out  current window pointer (3b)
//   wof_trap  out  one-cycle window-overflow pulse
//   wuf_trap  out  one-cycle window-underflow pulse
//   win_err   out  one-cycle pulse when save and restore collide

module windowed_regfile #(
  parameter int NWINDOWS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rd,
  input  logic [31:0]         wr_data,
  input  logic                wr_en,
  input  logic                save,
  input  logic                restore,
  input  logic [NWINDOWS-1:0] wim,
  output logic [31:0]         rd1_data,
  output logic [31:0]         rd2_data,
  output logic [2:0]          cwp,
  output logic                wof_trap,
  output logic                wuf_trap,
  output logic                win_err
);

  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int PW = $clog2(NPHYS);
  localparam logic [2:0] LAST_WIN = 3'(NWINDOWS - 1);

  // Physical word 0 exists only to keep the global indices natural; it is
  // never written because r0 writes are dropped.
  logic [31:0] regs [NPHYS];

  // Architectural register -> physical index for window w.
  function automatic logic [PW-1:0] phys_idx(input logic [4:0] r, input logic [2:0] w);
    int win_base;
    int in_base;
    int idx;
    win_base = 8 + 16 * int'(w);
    // ins alias the outs of the next window, wrapping at the top
    in_base  = 8 + 16 * ((w == LAST_WIN) ? 0 : int'(w) + 1);
    case (r[4:3])
      2'b00:   idx = int'(r);
      2'b01:   idx = win_base + int'(r[2:0]);
      2'b10:   idx = win_base + 8 + int'(r[2:0]);
      default: idx = in_base + int'(r[2:0]);
    endcase
    return PW'(idx);
  endfunction

  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd1_idx;
  logic [PW-1:0] rd2_idx;
  logic          wr_act;
  logic          hit1;
  logic          hit2;

  // All mapping uses the pre-update CWP, so a write issued alongside
  // SAVE/RESTORE lands in the old window.
  assign wr_idx  = phys_idx(rd, cwp);
  assign rd1_idx = phys_idx(rs1, cwp);
  assign rd2_idx = phys_idx(rs2, cwp);
  assign wr_act  = wr_en && (rd != 5'd0);
  assign hit1    = wr_act && (rs1 != 5'd0) && (rd1_idx == wr_idx);
  assign hit2    = wr_act && (rs2 != 5'd0) && (rd2_idx == wr_idx);

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
    end else if (wr_act) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Registered read ports with write-through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data <= '0;
      rd2_data <= '0;
    end else begin
      rd1_data <= (rs1 == 5'd0) ? 32'd0 : (hit1 ? wr_data : regs[rd1_idx]);
      rd2_data <= (rs2 == 5'd0) ? 32'd0 : (hit2 ? wr_data : regs[rd2_idx]);
    end
  end

  // Window pointer control
  logic [2:0] save_tgt;
  logic [2:0] restore_tgt;
  logic       save_blk;
  logic       restore_blk;
  logic [2:0] cwp_nxt;
  logic       wof_nxt;
  logic       wuf_nxt;
  logic       err_nxt;

  assign save_tgt    = (cwp == 3'd0) ? LAST_WIN : cwp - 3'd1;
  assign restore_tgt = (cwp == LAST_WIN) ? 3'd0 : cwp + 3'd1;

`ifdef WINDOW_TRAP_EN
  logic [NWINDOWS-1:0] save_oh;
  logic [NWINDOWS-1:0] restore_oh;
  assign save_oh     = NWINDOWS'(1) << save_tgt;
  assign restore_oh  = NWINDOWS'(1) << restore_tgt;
  assign save_blk    = |(wim & save_oh);
  assign restore_blk = |(wim & restore_oh);
`else
  // Mask is ignored; windows always move and traps never fire.
  logic unused_wim;
  assign unused_wim  = ^wim;
  assign save_blk    = 1'b0;
  assign restore_blk = 1'b0;
`endif

  always_comb begin
    cwp_nxt = cwp;
    wof_nxt = 1'b0;
    wuf_nxt = 1'b0;
    err_nxt = 1'b0;
    if (save && restore) begin
      err_nxt = 1'b1;
    end else if (save) begin
      if (save_blk) wof_nxt = 1'b1;
      else          cwp_nxt = save_tgt;
    end else if (restore) begin
      if (restore_blk) wuf_nxt = 1'b1;
      else             cwp_nxt = restore_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp      <= 3'd0;
      wof_trap <= 1'b0;
      wuf_trap <= 1'b0;
      win_err  <= 1'b0;
    end else begin
      cwp      <= cwp_nxt;
      wof_trap <= wof_nxt;
      wuf_trap <= wuf_nxt;
      win_err  <= err_nxt;
    end
  end

endmodule
